// File: rtl/sample_frame_loader.sv
// Packs a valid/ready PCM sample stream into FRAME_N-wide frames with a one-cycle frame_start pulse.
// Optional: LOADER_OFFSET_BIN_EN converts each accepted sample from two's complement to offset binary.
module sample_frame_loader #(
  parameter int DATA_W   = 16,
  parameter int FRAME_N  = 8,
  parameter int HOLD_CYC = 24,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic [CNT_W-1:0]          load_size,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      frame_start,
  output logic [FRAME_N*DATA_W-1:0] frame_data,
  output logic [CNT_W-1:0]          sample_cnt,
  output logic                      wav_done
);

  localparam int IDX_W  = $clog2(FRAME_N + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   bank [FRAME_N];
  logic [IDX_W-1:0]    wr_idx;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                      accept;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      limit_on;
  logic                      hit_limit;
  logic                      slot_last;
  logic                      issue;
  logic                      last_frame;
  logic [DATA_W-1:0]         conv_data;
  logic [FRAME_N*DATA_W-1:0] issue_data;

  assign accept    = in_valid && in_ready;
  assign cnt_inc   = sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign limit_on  = (load_size != '0);
  assign hit_limit = limit_on && (cnt_inc == load_size);
  assign slot_last = (wr_idx == IDX_W'(FRAME_N - 1));
  assign issue     = (state == FULL) && (hold_cnt == '0);
  // A limit lowered below the running count ends the stream with the frame in flight.
  assign last_frame = limit_on && (load_size <= sample_cnt);

`ifdef LOADER_OFFSET_BIN_EN
  assign conv_data = in_data ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
  assign conv_data = in_data;
`endif

  always_comb begin
    issue_data = '0;
    for (int k = 0; k < FRAME_N; k++) begin
      if (k < int'(wr_idx)) begin
        issue_data[k*DATA_W +: DATA_W] = bank[k];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: state_nxt = FILL;
      FILL: begin
        in_ready = 1'b1;
        if (accept && (slot_last || hit_limit)) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (hold_cnt == '0) begin
          state_nxt = last_frame ? DONE : FILL;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      wr_idx      <= '0;
      hold_cnt    <= '0;
      sample_cnt  <= '0;
      frame_start <= 1'b0;
      frame_data  <= '0;
      wav_done    <= 1'b0;
      for (int k = 0; k < FRAME_N; k++) begin
        bank[k] <= '0;
      end
    end else if (clear) begin
      // frame_data deliberately survives a soft clear.
      state       <= IDLE;
      wr_idx      <= '0;
      hold_cnt    <= '0;
      sample_cnt  <= '0;
      frame_start <= 1'b0;
      wav_done    <= 1'b0;
      for (int k = 0; k < FRAME_N; k++) begin
        bank[k] <= '0;
      end
    end else begin
      state       <= state_nxt;
      frame_start <= 1'b0;
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
      if (accept) begin
        bank[wr_idx[$clog2(FRAME_N)-1:0]] <= conv_data;
        wr_idx     <= wr_idx + IDX_W'(1);
        sample_cnt <= cnt_inc;
      end
      if (issue) begin
        frame_data  <= issue_data;
        frame_start <= 1'b1;
        hold_cnt    <= HOLD_W'(HOLD_CYC);
        wr_idx      <= '0;
        for (int k = 0; k < FRAME_N; k++) begin
          bank[k] <= '0;
        end
        if (last_frame) begin
          wav_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_loader.sv
// Scoreboard bench for sample_frame_loader: a sample-level model predicts frames, a monitor captures them.
module tb_sample_frame_loader;

  localparam int DW = 16;
  localparam int FN = 8;
  localparam int HC = 24;
  localparam int CW = 32;
  localparam int FW = FN * DW;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear;
  logic [CW-1:0] load_size;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          frame_start;
  logic [FW-1:0] frame_data;
  logic [CW-1:0] sample_cnt;
  logic          wav_done;

  sample_frame_loader #(
    .DATA_W(DW), .FRAME_N(FN), .HOLD_CYC(HC), .CNT_W(CW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load_size(load_size),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_start(frame_start), .frame_data(frame_data),
    .sample_cnt(sample_cnt), .wav_done(wav_done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every frame_start pulse is captured with its edge number and wav_done.
  logic [FW-1:0] got_q[$];
  int            got_edge_q[$];
  bit            got_done_q[$];
  always @(negedge clk) begin
    if (frame_start === 1'b1) begin
      got_q.push_back(frame_data);
      got_edge_q.push_back(cyc);
      got_done_q.push_back(wav_done);
    end
  end

  // Model state and expected-frame scoreboard.
  logic [FW-1:0] exp_q[$];
  bit            exp_last_q[$];
  logic [DW-1:0] m_bank[FN];
  int            m_idx;
  logic [CW-1:0] m_cnt;
  logic [FW-1:0] last_exp_frame;

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] d);
`ifdef LOADER_OFFSET_BIN_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_idx = 0;
    m_cnt = '0;
    for (int k = 0; k < FN; k++) m_bank[k] = '0;
    exp_q.delete(); exp_last_q.delete();
    got_q.delete(); got_edge_q.delete(); got_done_q.delete();
  endtask

  task automatic model_accept(input logic [DW-1:0] d);
    logic [FW-1:0] f;
    bit lim;
    m_bank[m_idx] = conv(d);
    m_idx++;
    m_cnt = m_cnt + 1;
    lim = (load_size != 0);
    if (m_idx == FN || (lim && m_cnt == load_size)) begin
      f = '0;
      for (int k = 0; k < FN; k++) f[k*DW +: DW] = m_bank[k];
      exp_q.push_back(f);
      exp_last_q.push_back(lim && (load_size <= m_cnt));
      last_exp_frame = f;
      for (int k = 0; k < FN; k++) m_bank[k] = '0;
      m_idx = 0;
    end
  endtask

  // Called at a negedge; returns the edge number that accepted the sample, or -1.
  task automatic send(input logic [DW-1:0] d, output int acc_edge);
    in_valid = 1'b1;
    in_data  = d;
    acc_edge = -1;
    for (int t = 0; t < 200; t++) begin
      if (in_ready === 1'b1) begin
        acc_edge = cyc + 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (acc_edge < 0) begin
      n_total++;
      $display("FAIL send_timeout: sample %h not accepted within 200 cycles", d);
    end else begin
      model_accept(d);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic wait_frames(input int extra);
    for (int t = 0; t < 200 && got_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (extra) @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; load_size = '0; in_valid = 1'b0; in_data = '0;
    last_exp_frame = '0;
    repeat (3) @(negedge clk);
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b want 0", frame_start); else n_pass++;
    n_total++; if (frame_data !== '0) $display("FAIL rst_frame_data: got %h want 0", frame_data); else n_pass++;
    n_total++; if (sample_cnt !== '0) $display("FAIL rst_sample_cnt: got %0d want 0", sample_cnt); else n_pass++;
    n_total++; if (wav_done !== 1'b0) $display("FAIL rst_wav_done: got %b want 0", wav_done); else n_pass++;
    n_rst = 1'b1;
    model_reset();
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_fill_entry: in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single_frame();
    int acc;
    load_size = '0;
    do_clear();
    for (int i = 1; i <= 8; i++) send(DW'(i), acc);
    wait_frames(30);
    n_total++; if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL single_count: got %0d frames want %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      n_total++; if (got_q[0] !== exp_q[0]) $display("FAIL single_data: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
      n_total++; if (got_edge_q[0] != acc + 1)
        $display("FAIL single_latency: frame_start edge %0d want %0d", got_edge_q[0], acc + 1); else n_pass++;
    end
    n_total++; if (wav_done !== 1'b0) $display("FAIL single_wav_done: got %b want 0", wav_done); else n_pass++;
    n_total++; if (sample_cnt !== 32'd8) $display("FAIL single_sample_cnt: got %0d want 8", sample_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc;
    load_size = '0;
    do_clear();
    for (int i = 1; i <= 17; i++) send(DW'(i), acc);
    wait_frames(5);
    n_total++; if (got_q.size() != 2 || exp_q.size() != 2)
      $display("FAIL b2b_count: got %0d frames want %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (got_q.size() == 2 && exp_q.size() == 2) begin
      for (int f = 0; f < 2; f++) begin
        n_total++; if (got_q[f] !== exp_q[f]) $display("FAIL b2b_data%0d: got %h want %h", f, got_q[f], exp_q[f]); else n_pass++;
      end
      n_total++; if (got_edge_q[1] - got_edge_q[0] != HC + 1)
        $display("FAIL b2b_hold_gap: got %0d edges want %0d", got_edge_q[1] - got_edge_q[0], HC + 1); else n_pass++;
      n_total++; if (acc != got_edge_q[1] + 1)
        $display("FAIL b2b_backpressure: 17th accept edge %0d want %0d", acc, got_edge_q[1] + 1); else n_pass++;
    end
    n_total++; if (sample_cnt !== 32'd17) $display("FAIL b2b_sample_cnt: got %0d want 17", sample_cnt); else n_pass++;
  endtask

  task automatic test_partial_frame();
    int acc;
    bit rdy_seen;
    load_size = 32'd10;
    do_clear();
    for (int i = 1; i <= 10; i++) send(DW'(i), acc);
    wait_frames(30);
    n_total++; if (got_q.size() != 2 || exp_q.size() != 2)
      $display("FAIL partial_count: got %0d frames want %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (got_q.size() == 2 && exp_q.size() == 2) begin
      for (int f = 0; f < 2; f++) begin
        n_total++; if (got_q[f] !== exp_q[f]) $display("FAIL partial_data%0d: got %h want %h", f, got_q[f], exp_q[f]); else n_pass++;
        n_total++; if (got_done_q[f] !== exp_last_q[f])
          $display("FAIL partial_done%0d: got %b want %b", f, got_done_q[f], exp_last_q[f]); else n_pass++;
      end
    end
    rdy_seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
    end
    n_total++; if (rdy_seen) $display("FAIL partial_ready_after_done: got 1 want 0"); else n_pass++;
    n_total++; if (sample_cnt !== 32'd10) $display("FAIL partial_sample_cnt: got %0d want 10", sample_cnt); else n_pass++;
  endtask

  task automatic test_exact_multiple();
    int acc;
    load_size = 32'd16;
    do_clear();
    for (int i = 1; i <= 16; i++) send(DW'(16'h0100 + i), acc);
    wait_frames(60);
    n_total++; if (got_q.size() != 2 || exp_q.size() != 2)
      $display("FAIL exact_count: got %0d frames want %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (got_q.size() == 2 && exp_q.size() == 2) begin
      n_total++; if (got_q[1] !== exp_q[1]) $display("FAIL exact_data: got %h want %h", got_q[1], exp_q[1]); else n_pass++;
      n_total++; if (got_done_q[0] !== 1'b0 || got_done_q[1] !== 1'b1)
        $display("FAIL exact_done: got %b%b want 01", got_done_q[0], got_done_q[1]); else n_pass++;
    end
  endtask

  task automatic test_load_change();
    int acc;
    load_size = '0;
    do_clear();
    for (int i = 1; i <= 10; i++) send(DW'(i), acc);
    load_size = 32'd5;
    for (int i = 11; i <= 16; i++) send(DW'(i), acc);
    wait_frames(30);
    n_total++; if (got_q.size() != 2 || exp_q.size() != 2)
      $display("FAIL change_count: got %0d frames want %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (got_q.size() == 2 && exp_q.size() == 2) begin
      n_total++; if (got_q[1] !== exp_q[1]) $display("FAIL change_data: got %h want %h", got_q[1], exp_q[1]); else n_pass++;
    end
    n_total++; if (wav_done !== 1'b1) $display("FAIL change_wav_done: got %b want 1", wav_done); else n_pass++;
    n_total++; if (sample_cnt !== 32'd16) $display("FAIL change_sample_cnt: got %0d want 16", sample_cnt); else n_pass++;
  endtask

  task automatic test_clear_accept();
    load_size = '0;
    do_clear();
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h5555; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    n_total++; if (sample_cnt !== '0) $display("FAIL clracc_sample_cnt: got %0d want 0", sample_cnt); else n_pass++;
    n_total++; if (frame_data !== last_exp_frame)
      $display("FAIL clracc_frame_hold: got %h want %h", frame_data, last_exp_frame); else n_pass++;
    n_total++; if (wav_done !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL clracc_state: wav_done %b in_ready %b want 0 0", wav_done, in_ready); else n_pass++;
  endtask

  task automatic test_rst_mid_frame();
    int acc;
    load_size = '0;
    do_clear();
    for (int i = 1; i <= 5; i++) send(DW'(16'h0A00 + i), acc);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    for (int i = 1; i <= 8; i++) send(DW'(i), acc);
    wait_frames(10);
    n_total++; if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL rstmid_count: got %0d frames want %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (got_q.size() == 1 && exp_q.size() == 1) begin
      n_total++; if (got_q[0] !== exp_q[0]) $display("FAIL rstmid_data: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
    end
    n_total++; if (sample_cnt !== 32'd8) $display("FAIL rstmid_sample_cnt: got %0d want 8", sample_cnt); else n_pass++;
  endtask

  task automatic test_offset_binary();
    int acc;
    logic [DW-1:0] want [3];
`ifdef LOADER_OFFSET_BIN_EN
    want[0] = 16'h0000; want[1] = 16'hFFFF; want[2] = 16'h8000;
`else
    want[0] = 16'h8000; want[1] = 16'h7FFF; want[2] = 16'h0000;
`endif
    load_size = 32'd3;
    do_clear();
    send(16'h8000, acc);
    send(16'h7FFF, acc);
    send(16'h0000, acc);
    wait_frames(5);
    n_total++; if (got_q.size() != 1) $display("FAIL offset_count: got %0d frames want 1", got_q.size()); else n_pass++;
    if (got_q.size() == 1) begin
      for (int k = 0; k < FN; k++) begin
        n_total++;
        if (got_q[0][k*DW +: DW] !== ((k < 3) ? want[k] : 16'h0000))
          $display("FAIL offset_slot%0d: got %h want %h", k + 1, got_q[0][k*DW +: DW], (k < 3) ? want[k] : 16'h0000);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_partial_frame();
    test_exact_multiple();
    test_load_change();
    test_clear_accept();
    test_rst_mid_frame();
    test_offset_binary();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
